// File: rtl/uart_tx_frame_gen.sv
// Asynchronous UART transmitter: start bit, 5..DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits, plus a level-driven break generator.
module uart_tx_frame_gen #(
    parameter int DATA_W = 9,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [2:0]        parity_mode,
    input  logic              stop2,
    input  logic              send_break,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t             state, state_n;
    logic               tx_r, tx_n;
    logic [DATA_W-1:0]  data_r, data_n;
    logic [LEN_W-1:0]   len_r, len_n;
    logic [2:0]         par_r, par_n;
    logic               stop2_r, stop2_n;
    logic [LEN_W-1:0]   bit_cnt, bit_cnt_n;
    logic [1:0]         stop_left, stop_left_n;
    logic               done_en, done_en_n;
    logic               done_r, done_n;
    logic               accept;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len < MIN_LEN)
            return MIN_LEN;
        else if (len > MAX_LEN)
            return MAX_LEN;
        else
            return len;
    endfunction

    // Zero the unused upper bits so parity can simply XOR the whole word.
    function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                    input logic [LEN_W-1:0]  len);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) < len)
                m[i] = d[i];
        end
        return m;
    endfunction

    function automatic logic parity_on(input logic [2:0] mode);
        return (mode >= 3'd1) && (mode <= 3'd4);
    endfunction

    function automatic logic parity_bit(input logic [DATA_W-1:0] d,
                                        input logic [2:0]        mode);
        case (mode)
            3'b001:  return ~(^d);
            3'b010:  return ^d;
            3'b011:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign tx_ready = (state == ST_IDLE) && !send_break;
    assign accept   = tx_valid && tx_ready;
    assign tx       = tx_r;
    assign tx_busy  = (state != ST_IDLE);
    assign tx_done  = done_r;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            tx_r      <= 1'b1;
            data_r    <= '0;
            len_r     <= '0;
            par_r     <= '0;
            stop2_r   <= 1'b0;
            bit_cnt   <= '0;
            stop_left <= '0;
            done_en   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            tx_r      <= tx_n;
            data_r    <= data_n;
            len_r     <= len_n;
            par_r     <= par_n;
            stop2_r   <= stop2_n;
            bit_cnt   <= bit_cnt_n;
            stop_left <= stop_left_n;
            done_en   <= done_en_n;
            done_r    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        tx_n        = tx_r;
        data_n      = data_r;
        len_n       = len_r;
        par_n       = par_r;
        stop2_n     = stop2_r;
        bit_cnt_n   = bit_cnt;
        stop_left_n = stop_left;
        done_en_n   = done_en;
        done_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                // Break has priority; tx_ready is already low when it is requested.
                if (send_break) begin
                    tx_n    = 1'b0;
                    state_n = ST_BREAK;
                end else if (accept) begin
                    len_n     = clamp_len(data_len);
                    data_n    = mask_data(tx_data, clamp_len(data_len));
                    par_n     = parity_mode;
                    stop2_n   = stop2;
                    done_en_n = 1'b1;
                    state_n   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (baud_tick) begin
                    tx_n    = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_n      = data_r[0];
                    bit_cnt_n = LEN_W'(1);
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == len_r) begin
                        if (parity_on(par_r)) begin
                            tx_n    = parity_bit(data_r, par_r);
                            state_n = ST_PARITY;
                        end else begin
                            tx_n        = 1'b1;
                            stop_left_n = stop2_r ? 2'd2 : 2'd1;
                            state_n     = ST_STOP;
                        end
                    end else begin
                        tx_n      = data_r[bit_cnt];
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_n        = 1'b1;
                    stop_left_n = stop2_r ? 2'd2 : 2'd1;
                    state_n     = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_left == 2'd1) begin
                        done_n  = done_en;
                        state_n = ST_IDLE;
                    end else begin
                        stop_left_n = stop_left - 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Two mark bit times follow a break, without a done pulse.
                if (!send_break) begin
                    tx_n        = 1'b1;
                    stop_left_n = 2'd2;
                    done_en_n   = 1'b0;
                    state_n     = ST_STOP;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: per-frame expected line bits are
// queued at accept and popped on each baud tick.
module tb_uart_tx_frame_gen;

    localparam int DW = 9;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          baud_tick;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [LW-1:0] data_len;
    logic [2:0]    parity_mode;
    logic          stop2;
    logic          send_break;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    logic exp_q[$];

    uart_tx_frame_gen #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .baud_tick   (baud_tick),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .data_len    (data_len),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .send_break  (send_break),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1)
            done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Queue the full expected line sequence, then present the word.
    task automatic accept_frame(input logic [DW-1:0] d, input logic [LW-1:0] len,
                                input logic [2:0] pm, input logic s2, input logic tick_on_acc);
        int   n;
        logic x;
        n = (len < 5) ? 5 : ((len > DW) ? DW : int'(len));
        x = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            x = x ^ d[i];
        end
        case (pm)
            3'b001: exp_q.push_back(~x);
            3'b010: exp_q.push_back(x);
            3'b011: exp_q.push_back(1'b1);
            3'b100: exp_q.push_back(1'b0);
            default: ;
        endcase
        exp_q.push_back(1'b1);
        if (s2)
            exp_q.push_back(1'b1);

        tx_data     = d;
        data_len    = len;
        parity_mode = pm;
        stop2       = s2;
        tx_valid    = 1'b1;
        baud_tick   = tick_on_acc;
        #1;
        chk("ready_before_accept", tx_ready, 1);
        cyc();
        tx_valid  = 1'b0;
        baud_tick = 1'b0;
        chk("accept_ready_low", tx_ready, 0);
        chk("accept_busy", tx_busy, 1);
        chk("load_tx_idle", tx, 1);
        tx_data     = DW'($urandom);
        data_len    = LW'($urandom);
        parity_mode = 3'($urandom);
        stop2       = 1'($urandom);
        cyc();
        chk("load_waits_tick", tx, 1);
    endtask

    task automatic tick_and_check(input string tag);
        logic e;
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, tx, e);
            chk({tag, "_ready_low"}, tx_ready, 0);
            cyc();
            chk({tag, "_hold"}, tx, e);
        end
    endtask

    task automatic finish_frame(input string tag);
        int d0;
        d0 = done_cnt;
        while (exp_q.size() > 0)
            tick_and_check(tag);
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        chk({tag, "_end_tx"}, tx, 1);
        chk({tag, "_end_done"}, tx_done, 1);
        chk({tag, "_end_busy"}, tx_busy, 0);
        chk({tag, "_end_ready"}, tx_ready, 1);
        cyc();
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_done_single"}, tx_done, 0);
    endtask

    initial begin
        int d0;
        aresetn     = 1'b0;
        baud_tick   = 1'b0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        data_len    = 4'd8;
        parity_mode = 3'b000;
        stop2       = 1'b0;
        send_break  = 1'b0;
        repeat (3) cyc();
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready", tx_ready, 1);
        aresetn = 1'b1;
        cyc();
        chk("post_rst_ready", tx_ready, 1);

        // 8N1 0xA5, with a tick on the accept cycle that must be ignored
        accept_frame(9'h0A5, 4'd8, 3'b000, 1'b0, 1'b1);
        finish_frame("8n1_a5");

        accept_frame(9'h0A5, 4'd8, 3'b010, 1'b0, 1'b0);
        finish_frame("8e1_a5");
        accept_frame(9'h0A5, 4'd8, 3'b001, 1'b0, 1'b0);
        finish_frame("8o1_a5");

        accept_frame(9'h1FF, 4'd9, 3'b011, 1'b1, 1'b0);
        finish_frame("9m2_1ff");

        accept_frame(9'h03F, 4'd3, 3'b010, 1'b0, 1'b0);
        finish_frame("len3_clamp");
        accept_frame(9'h155, 4'd12, 3'b010, 1'b0, 1'b0);
        finish_frame("len12_clamp");

        accept_frame(9'h00F, 4'd6, 3'b100, 1'b1, 1'b0);
        finish_frame("6s2_space");
        accept_frame(9'h0C3, 4'd7, 3'b111, 1'b0, 1'b0);
        finish_frame("7_pm7_none");

        // Break requested together with a valid word
        d0          = done_cnt;
        send_break  = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = 9'h055;
        #1;
        chk("brk_ready_low", tx_ready, 0);
        cyc();
        chk("brk_tx_low", tx, 0);
        chk("brk_busy", tx_busy, 1);
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        chk("brk_tick_hold", tx, 0);
        tx_valid   = 1'b0;
        send_break = 1'b0;
        cyc();
        chk("brk_release_tx", tx, 1);
        chk("brk_release_ready", tx_ready, 0);
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        chk("brk_mark1_ready", tx_ready, 0);
        chk("brk_mark1_tx", tx, 1);
        baud_tick = 1'b1;
        cyc();
        baud_tick = 1'b0;
        chk("brk_mark2_ready", tx_ready, 1);
        chk("brk_mark2_busy", tx_busy, 0);
        chk("brk_no_done", tx_done, 0);
        cyc();
        chk("brk_done_count", done_cnt - d0, 0);

        // Asynchronous reset in the middle of the data bits
        d0 = done_cnt;
        accept_frame(9'h000, 4'd8, 3'b000, 1'b0, 1'b0);
        tick_and_check("rst_mid_start");
        tick_and_check("rst_mid_d0");
        tick_and_check("rst_mid_d1");
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", tx_busy, 0);
        exp_q.delete();
        cyc();
        cyc();
        aresetn = 1'b1;
        cyc();
        chk("rst_mid_no_done", done_cnt - d0, 0);
        accept_frame(9'h05A, 4'd8, 3'b010, 1'b1, 1'b0);
        finish_frame("after_rst_8e2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
Next-generation asynchronous UART transmitter. Serialises a parameter-width word using runtime-selectable data length, parity mode and 1/2 stop bits. Also supports break generation and uses a valid/ready input handshake. It sits between the TX FIFO/APB register logic and the pad. Bit timing comes from an external baud generator via a one-clk baud_tick.

Parameters:
DATA_W, 9, maximum data bits per frame (legal 5..9)
LEN_W, 4, width of data_len field

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk pulse per bit period
tx_data  in  DATA_W  word to send, LSB first
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a word this cycle
data_len  in  LEN_W  data bits per frame; sampled at accept
parity_mode  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space, others = none; sampled at accept
stop2  in  1  1 = two stop bits; sampled at accept
send_break  in  1  level request to hold line low
tx  out  1  serial line, idle high
tx_busy  out  1  state != IDLE
tx_done  out  1  one-clk pulse at end of last stop bit of a data frame

Behaviour:
- Reset: clk is clk; reset is aresetn, asynchronous, active-low.
  - Reset is asynchronous; all registers clear immediately on aresetn low.
  - Outputs in and after reset: tx=1, tx_busy=0, tx_done=0, state=IDLE.
  - tx_ready=1 after reset unless send_break=1.
- Reset mid-frame: frame is abandoned and tx returns to 1 immediately; no tx_done.
- States: IDLE, LOAD, START, DATA, PARITY, STOP, BREAK. Every transition except IDLE->LOAD, IDLE->BREAK and BREAK->STOP occurs only on a clk with baud_tick=1.
- tx_ready = (state==IDLE) & !send_break, combinational.
- Accept = tx_valid & tx_ready.
- On accept, latch tx_data, data_len (clamped), parity_mode and stop2, then go to LOAD. A baud_tick on the accept cycle is ignored.
- Clamp rule: data_len<5 -> 5; data_len>DATA_W -> DATA_W.
- Bits of tx_data at or above the clamped length are ignored for both shifting and parity.
- LOAD: on tick, tx<=0 (start bit begins) -> START.
  - Consequence: at least one mark bit time exists between back-to-back frames.
- START: on tick, tx<=data[0], bit_cnt<=1 -> DATA.
- DATA: on tick:
  - If bit_cnt==len and parity is enabled: tx<=parity bit -> PARITY.
  - If bit_cnt==len and parity is none: tx<=1, stop_left<=stop2?2:1 -> STOP.
  - Otherwise: tx<=data[bit_cnt], bit_cnt++.
- Parity bit:
  - even = XOR of the len data bits
  - odd = its inverse
  - mark = 1, space = 0
- PARITY: on tick, tx<=1, stop_left loaded -> STOP.
- STOP: on tick:
  - If stop_left==1: go to IDLE, and tx_done=1 for that one clk (data frames only).
  - Otherwise stop_left--.
  - tx stays 1 throughout.
- BREAK:
  - Entered from IDLE on the clk after send_break=1 is seen; tx<=0 on that edge, not tick-aligned.
  - Held while send_break=1.
  - When send_break drops: tx<=1, stop_left<=2, state STOP with the done flag suppressed. This guarantees 2 mark bit times after a break.
- Simultaneous events:
  - send_break with tx_valid in IDLE: break wins and no accept occurs.
  - send_break asserted during a frame is ignored until IDLE; the frame completes first.
- baud_tick in IDLE or BREAK has no effect.
- Config inputs changing mid-frame have no effect on the current frame.

Test Plan:
- 8N1, tx_valid with 0xA5, data_len=8, parity 000, stop2=0 -> per tick after LOAD, tx = 0,1,0,1,0,0,1,0,1 then 1; tx_done pulses once at end of the stop bit; tx_ready=0 from the accept cycle until IDLE.
- 0xA5 with 8 bits, even parity then odd parity -> parity bit 0 (even) and 1 (odd); frame totals 11 bit times.
- 0x1FF with 9 bits, mark parity, stop2=1 -> 9 ones, parity 1, 2 stop bits; tx_done exactly once after the second stop bit.
- data_len=3 with 0x3F -> clamped to 5 bits (1,1,1,1,1); data_len=12 clamps to 9.
- send_break=1 together with tx_valid=1 in IDLE -> no accept, tx=0 the next clk. After send_break drops, tx=1 for 2 ticks, then tx_ready=1; no tx_done.
- aresetn pulsed low during DATA -> tx=1 asynchronously, tx_busy=0, no tx_done; the next accepted word transmits normally.
